dense_layer_engine: RTL and testbench
=====================================

# dense_layer_engine

Parametrised fully-connected classifier layer behind the CPU register bus, successor to the fixed softmax top with dummy results. It holds an input image buffer, a weight memory, and per-class bias registers, all written over the CPU bus. On a start command it sequences N_OUT dot products of N_IN length with one MAC per cycle. It stores the N_OUT signed scores in readable result registers and optionally reports the argmax class.

## Interface
- N_IN, 784: input vector length (pixels), 1..65536
- N_OUT, 10: output classes, 1..256, N_IN*N_OUT ≤ 65536
- ACC_W, 32: accumulator/result width, 17..32
- CLK in 1: sole clock, rising edge
- RESET in 1: synchronous reset, active-high
- WR in 1: CPU write strobe, one cycle per access
- RD in 1: CPU read strobe, one cycle per access
- ADR in 18: CPU address; [17:16] region, [15:0] index
- WDATA in 32: CPU write data
- RDATA out 32: CPU read data, registered

## Operation
- Region 00, control/status:
  - index 0 write: bit0=START.
  - index 0 read: bit0 BUSY, bit1 DONE, bit2 ERR (sticky), [15:8] ARGMAX, rest 0.
  - index 1 write: any value clears DONE and ERR.
- Region 01, image: WDATA[7:0] unsigned pixel at index (< N_IN). Readable.
- Region 10, weights: WDATA[7:0] signed weight at index out*N_IN+in. Readable.
- Region 11, bias and results:
  - ADR[15]=0: bias[ADR[7:0]], signed ACC_W bits, read/write.
  - ADR[15]=1: result[ADR[7:0]], read-only, sign-extended to 32 bits.
- Out-of-range indices: writes dropped; reads return 0.
- FSM:
  - IDLE: on START → RUN; clears DONE, out_cnt=0, in_cnt=0, acc=0.
  - RUN: issues image/weight reads at in_cnt each cycle. The MAC adds the previous cycle's product. After in_cnt=N_IN-1 → DRAIN.
  - DRAIN: one cycle to accumulate the last product → STORE.
  - STORE: result[out_cnt]=acc+bias[out_cnt]; acc=0, in_cnt=0. If out_cnt=N_OUT-1 → IDLE and set DONE; else out_cnt++ → RUN.
- Arithmetic:
  - Product is unsigned8 × signed8, giving a signed 17-bit value, sign-extended to ACC_W.
  - Sums wrap modulo 2^ACC_W; no saturation.
- Boundary cases:
  - START while BUSY: ignored.
  - Memory or bias writes while BUSY: dropped and ERR set. Reads while BUSY are served.
  - Simultaneous WR and RD: write performed; RDATA returns the pre-write value.
- Argmax: signed compare; a tie keeps the lowest index. Updated in STORE; valid when DONE=1.

## Timing
- Reset (any state, including mid-run):
  - FSM→IDLE; BUSY, DONE, ERR, ARGMAX=0; all results=0; RDATA=0; counters=0.
  - Image, weight, and bias contents are not reset.
- RDATA valid the cycle after RD; holds until the next RD.
- BUSY=1 from the cycle after the START write.
- Each class takes N_IN+2 cycles.
- DONE=1 and BUSY=0 at N_OUT*(N_IN+2)+1 cycles after the START write edge.

## Configuration
- ARGMAX_EN defined: running-max comparator and index register built; STATUS[15:8]=argmax.
- ARGMAX_EN not defined: no comparator; STATUS[15:8] reads 0. Results are unaffected.

## Structure
- Shared package holds:
  - region codes (REG_CTRL=2'b00, REG_IMG=2'b01, REG_WGT=2'b10, REG_BR=2'b11);
  - control/status bit positions;
  - FSM state enum.
- One sub-module, dl_sram: single-port synchronous RAM, parameterised depth/width, 1-cycle read. Instanced for the image (N_IN×8) and weights (N_IN*N_OUT×8).
- CPU port muxes addresses while IDLE; the FSM owns the addresses while BUSY.

## Test plan
All tests use N_IN=4, N_OUT=3.
- Sum test: image all 1, weight rows = 1, 2, 3, bias 0, START → results 4, 8, 12; ARGMAX=2; DONE exactly 19 cycles after START.
- Signed test: image 255, weights −128, bias[0]=100 → result[0]=−130460 (0xFFFE0264 when read).
- Tie test: results equal, e.g. 5, 5, 2 → ARGMAX=0. With ARGMAX_EN undefined → STATUS[15:8]=0.
- Busy collisions: START at cycle 5 of a run and weight write during BUSY → run completes unchanged; ERR=1; write to index 1 clears DONE and ERR.
- Reset mid-run: RESET at cycle 8 → next cycle STATUS=0 and results 0. Re-START with preserved memories → results 4, 8, 12.

Source files
------------

// File: rtl/dense_layer_engine_pkg.sv
// Shared types and register map for the dense layer engine.
// Region codes, control/status bit positions and the sequencer states.
package dense_layer_engine_pkg;

  localparam logic [1:0] REG_CTRL = 2'b00;
  localparam logic [1:0] REG_IMG  = 2'b01;
  localparam logic [1:0] REG_WGT  = 2'b10;
  localparam logic [1:0] REG_BR   = 2'b11;

  localparam int CTRL_START = 0;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_ARG_LO  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_STORE
  } state_t;

endpackage

// File: rtl/dense_layer_engine_sram.sv
// Single-port synchronous RAM, one-cycle registered read.
// A same-cycle read and write returns the old word.
module dl_sram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dense_layer_engine.sv
// Fully-connected classifier layer on the CPU register bus.
// Define ARGMAX_EN to build the running-max argmax tracker.
module dense_layer_engine
  import dense_layer_engine_pkg::*;
#(
  parameter int N_IN  = 784,
  parameter int N_OUT = 10,
  parameter int ACC_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  logic        rd,
  input  logic [17:0] adr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int NW  = N_IN * N_OUT;
  localparam int IAW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int WAW = (NW > 1) ? $clog2(NW) : 1;
  localparam int OAW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_t state_q, state_d;
  logic busy, done_q, err_q, mac_v;
  logic [IAW-1:0] in_cnt;
  logic [OAW-1:0] out_cnt;
  logic [WAW-1:0] w_ptr;
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [ACC_W-1:0] bias [N_OUT];
  logic signed [ACC_W-1:0] res  [N_OUT];
  logic [7:0] arg_idx;

  logic [1:0]  region;
  logic [15:0] idx;
  logic img_hit, wgt_hit, bias_hit, res_hit;
  logic start, clr, mem_wr, last;

  assign region   = adr[17:16];
  assign idx      = adr[15:0];
  assign busy     = (state_q != S_IDLE);
  assign img_hit  = (region == REG_IMG) && (int'(idx) < N_IN);
  assign wgt_hit  = (region == REG_WGT) && (int'(idx) < NW);
  assign bias_hit = (region == REG_BR) && !adr[15]
                    && (int'(adr[7:0]) < N_OUT);
  assign res_hit  = (region == REG_BR) && adr[15]
                    && (int'(adr[7:0]) < N_OUT);
  assign start    = wr && (region == REG_CTRL) && (idx == 16'd0)
                    && wdata[CTRL_START];
  assign clr      = wr && (region == REG_CTRL) && (idx == 16'd1);
  assign mem_wr   = wr && (region != REG_CTRL)
                    && !((region == REG_BR) && adr[15]);
  assign last     = (int'(out_cnt) == N_OUT - 1);

  // The sequencer owns the RAM addresses whenever it is busy
  logic [7:0] img_q, wgt_q;
  logic img_rd, wgt_rd;
  assign img_rd = rd && img_hit && !busy;
  assign wgt_rd = rd && wgt_hit && !busy;

  dl_sram #(.DEPTH(N_IN), .WIDTH(8), .AW(IAW)) u_img (
    .clk   (clk),
    .we    (wr && img_hit && !busy),
    .re    (busy ? (state_q == S_RUN) : img_rd),
    .addr  (busy ? in_cnt : idx[IAW-1:0]),
    .wdata (wdata[7:0]),
    .rdata (img_q)
  );

  dl_sram #(.DEPTH(NW), .WIDTH(8), .AW(WAW)) u_wgt (
    .clk   (clk),
    .we    (wr && wgt_hit && !busy),
    .re    (busy ? (state_q == S_RUN) : wgt_rd),
    .addr  (busy ? w_ptr : idx[WAW-1:0]),
    .wdata (wdata[7:0]),
    .rdata (wgt_q)
  );

  logic signed [16:0] prod;
  assign prod = $signed({1'b0, img_q}) * $signed(wgt_q);
  assign sum  = acc + bias[out_cnt];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (int'(in_cnt) == N_IN - 1) state_d = S_DRAIN;
      S_DRAIN: state_d = S_STORE;
      S_STORE: state_d = last ? S_IDLE : S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      w_ptr   <= '0;
      mac_v   <= 1'b0;
      acc     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_OUT; i++) res[i] <= '0;
    end else begin
      state_q <= state_d;
      mac_v   <= (state_q == S_RUN);
      if (mac_v) acc <= acc + ACC_W'(prod);
      unique case (state_q)
        S_IDLE: if (start) begin
          in_cnt  <= '0;
          out_cnt <= '0;
          w_ptr   <= '0;
          acc     <= '0;
          done_q  <= 1'b0;
        end
        S_RUN: begin
          in_cnt <= in_cnt + 1'b1;
          w_ptr  <= w_ptr + 1'b1;
        end
        S_STORE: begin
          res[out_cnt] <= sum;
          acc    <= '0;
          in_cnt <= '0;
          if (last) done_q <= 1'b1;
          else out_cnt <= out_cnt + 1'b1;
        end
        default: ;
      endcase
      if (busy && mem_wr) err_q <= 1'b1;
      if (clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!busy && wr && bias_hit)
      bias[adr[OAW-1:0]] <= wdata[ACC_W-1:0];
  end

`ifdef ARGMAX_EN
  logic signed [ACC_W-1:0] max_q;
  logic [7:0] arg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
      arg_q <= '0;
    end else if (state_q == S_STORE) begin
      if (out_cnt == '0 || sum > max_q) begin
        max_q <= sum;
        arg_q <= 8'(out_cnt);
      end
    end
  end

  assign arg_idx = arg_q;
`else
  assign arg_idx = '0;
`endif

  logic [31:0] rd_val, reg_q, hold_q;
  logic [1:0]  sel_q;
  logic        rd_q;

  always_comb begin
    rd_val = '0;
    if (region == REG_CTRL && idx == 16'd0)
      rd_val = {16'h0, arg_idx, 5'h0, err_q, done_q, busy};
    else if (bias_hit)
      rd_val = 32'(bias[adr[OAW-1:0]]);
    else if (res_hit)
      rd_val = 32'(res[adr[OAW-1:0]]);
  end

  // RAM words arrive a cycle late; hold_q keeps RDATA stable between reads
  always_comb begin
    rdata = hold_q;
    if (rd_q) begin
      unique case (sel_q)
        REG_IMG: rdata = {24'h0, img_q};
        REG_WGT: rdata = {{24{wgt_q[7]}}, wgt_q};
        default: rdata = reg_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q   <= 1'b0;
      sel_q  <= REG_CTRL;
      reg_q  <= '0;
      hold_q <= '0;
    end else begin
      rd_q   <= rd;
      hold_q <= rdata;
      if (rd) begin
        reg_q <= rd_val;
        sel_q <= img_rd ? REG_IMG : (wgt_rd ? REG_WGT : REG_CTRL);
      end
    end
  end

endmodule

// File: tb/tb_dense_layer_engine.sv
// Scoreboard bench for dense_layer_engine, N_IN=4, N_OUT=3.
// Expected argmax follows whether ARGMAX_EN is defined.
module tb_dense_layer_engine;
  import dense_layer_engine_pkg::*;

  localparam int NI = 4;
  localparam int NO = 3;
`ifdef ARGMAX_EN
  localparam bit ARG_ON = 1'b1;
`else
  localparam bit ARG_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, wr, rd;
  logic [17:0] adr;
  logic [31:0] wdata, rdata;

  dense_layer_engine #(.N_IN(NI), .N_OUT(NO), .ACC_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .rd    (rd),
    .adr   (adr),
    .wdata (wdata),
    .rdata (rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rd_q    = 1'b0;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp, logic [31:0] mask);
    n_tests++;
    if ((act & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (mask %h)", nm, act, exp, mask);
    end
  endtask

  always @(posedge clk) rd_q <= rd;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_q) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_read: got %h want none", rdata);
        end else begin
          e = sb.pop_front();
          check(e.name, rdata, e.exp, e.mask);
        end
      end
    end
  end

  function automatic logic [17:0] a(logic [1:0] r, int i);
    return {r, 16'(i)};
  endfunction

  function automatic logic [31:0] st(bit b, bit d, bit er, int arg);
    return {16'h0, (ARG_ON ? 8'(arg) : 8'h0), 5'h0, er, d, b};
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_t(logic [17:0] ad, logic [31:0] d);
    adr = ad; wdata = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_t(logic [17:0] ad, logic [31:0] ex, string nm,
                      logic [31:0] m = 32'hFFFF_FFFF);
    adr = ad; rd = 1'b1;
    sb.push_back('{nm, ex, m});
    tick();
    rd = 1'b0;
  endtask

  // Status polls read at edges from..to; DONE first shows at done_at
  task automatic poll(int from, int to, int done_at, string nm);
    for (int j = from; j <= to; j++)
      rd_t(a(REG_CTRL, 0), (j >= done_at) ? 32'h2 : 32'h1, nm, 32'h3);
  endtask

  task automatic load_img(logic [7:0] v);
    for (int i = 0; i < NI; i++) wr_t(a(REG_IMG, i), {24'h0, v});
  endtask

  task automatic load_rows123();
    for (int o = 0; o < NO; o++)
      for (int i = 0; i < NI; i++)
        wr_t(a(REG_WGT, o * NI + i), 32'(o + 1));
  endtask

  task automatic chk_res(int k, logic [31:0] ex, string nm);
    rd_t(a(REG_BR, 16'h8000 | k), ex, nm);
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0; adr = '0; wdata = '0;
    tick(3);
    reset = 1'b0;
    check("rdata_reset", rdata, 32'h0, 32'hFFFF_FFFF);
    rd_t(a(REG_CTRL, 0), 32'h0, "status_reset");
    chk_res(0, 32'h0, "res0_reset");

    load_img(8'd1);
    load_rows123();
    for (int o = 0; o < NO; o++) wr_t(a(REG_BR, o), 32'h0);
    wr_t(a(REG_IMG, 4), 32'h7);
    rd_t(a(REG_IMG, 2), 32'h1, "img_readback");
    rd_t(a(REG_WGT, 5), 32'h2, "wgt_readback");
    rd_t(a(REG_IMG, 4), 32'h0, "img_out_of_range");
    rd_t(a(REG_BR, 3), 32'h0, "bias_out_of_range");

    // Sum test: DONE seen by the read at the 19th edge after START
    wr_t(a(REG_CTRL, 0), 32'h1);
    poll(1, 20, 19, "sum_done_timing");
    chk_res(0, 32'd4, "sum_res0");
    chk_res(1, 32'd8, "sum_res1");
    chk_res(2, 32'd12, "sum_res2");
    rd_t(a(REG_CTRL, 0), st(0, 1, 0, 2), "sum_status");

    // Busy collisions: re-START at cycle 5, weight write at cycle 6
    wr_t(a(REG_CTRL, 0), 32'h1);
    tick(4);
    wr_t(a(REG_CTRL, 0), 32'h1);
    wr_t(a(REG_WGT, 0), 32'h63);
    poll(7, 20, 19, "busy_done_timing");
    rd_t(a(REG_CTRL, 0), st(0, 1, 1, 2), "busy_status_err");
    rd_t(a(REG_WGT, 0), 32'h1, "busy_wgt_kept");
    chk_res(2, 32'd12, "busy_res2");
    wr_t(a(REG_CTRL, 1), 32'h0);
    rd_t(a(REG_CTRL, 0), st(0, 0, 0, 2), "status_cleared");

    // Signed test, with a simultaneous bias write and read
    load_img(8'd255);
    for (int i = 0; i < NI * NO; i++) wr_t(a(REG_WGT, i), 32'h80);
    adr = a(REG_BR, 0); wdata = 32'd100; wr = 1'b1; rd = 1'b1;
    sb.push_back('{"wr_rd_old_value", 32'h0, 32'hFFFF_FFFF});
    tick();
    wr = 1'b0; rd = 1'b0;
    rd_t(a(REG_BR, 0), 32'd100, "bias_written");
    wr_t(a(REG_CTRL, 0), 32'h1);
    tick(22);
    chk_res(0, 32'hFFFE_0264, "signed_res0");
    chk_res(1, 32'hFFFE_0200, "signed_res1");
    rd_t(a(REG_CTRL, 0), st(0, 1, 0, 0), "signed_status");

    // Tie test: results 5, 5, 2
    load_img(8'd1);
    for (int i = 0; i < NI * NO; i++) wr_t(a(REG_WGT, i), 32'h0);
    wr_t(a(REG_WGT, 0), 32'h2);
    for (int i = 1; i < NI; i++) wr_t(a(REG_WGT, i), 32'h1);
    for (int i = 0; i < NI - 1; i++) wr_t(a(REG_WGT, NI + i), 32'h1);
    wr_t(a(REG_WGT, 2 * NI - 1), 32'h2);
    wr_t(a(REG_BR, 0), 32'h0);
    wr_t(a(REG_BR, 2), 32'h2);
    wr_t(a(REG_CTRL, 0), 32'h1);
    tick(22);
    chk_res(0, 32'd5, "tie_res0");
    chk_res(1, 32'd5, "tie_res1");
    chk_res(2, 32'd2, "tie_res2");
    rd_t(a(REG_CTRL, 0), st(0, 1, 0, 0), "tie_status");

    // Reset mid-run, then re-run on preserved memories
    load_rows123();
    wr_t(a(REG_BR, 2), 32'h0);
    wr_t(a(REG_CTRL, 0), 32'h1);
    tick(7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_t(a(REG_CTRL, 0), 32'h0, "midrst_status");
    chk_res(0, 32'h0, "midrst_res0");
    wr_t(a(REG_CTRL, 0), 32'h1);
    tick(22);
    chk_res(0, 32'd4, "rerun_res0");
    chk_res(1, 32'd8, "rerun_res1");
    chk_res(2, 32'd12, "rerun_res2");
    rd_t(a(REG_CTRL, 0), st(0, 1, 0, 2), "rerun_status");

    tick(3);
    check("sb_drain", 32'(sb.size()), 32'h0, 32'hFFFF_FFFF);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
